// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared constants for the ALU command sequencer and the 4-bit registered ALU.
//   Holds the opcode codes (ALU select codes plus the sequencer-local NOP/LDI),
//   the sequencer state encoding and the default datapath sizes.
package alu_seq_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int NREGS_DEF = 4;
  localparam int RA_W_DEF  = 2;

  // Opcodes. 0010..1000 are ALU select codes; 1001..1111 are forwarded to
  // the ALU untouched (the ALU answers 0 for them).
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LDI  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_NOTA = 4'b0100;
  localparam logic [3:0] OP_NOTB = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  // Anything other than the two local codes is issued to the ALU.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op != OP_NOP) && (op != OP_LDI);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if
//   Bundles the sequencer's command handshake, ALU operand/result bus and the
//   result strobe.
//   slave  : sequencer side (takes commands and alu_result, drives the rest).
//   master : environment side (issues commands, returns alu_result).
interface alu_seq_if #(
  parameter int WIDTH = 4,
  parameter int RA_W  = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [RA_W-1:0]  cmd_rd;
  logic [RA_W-1:0]  cmd_rs1;
  logic [RA_W-1:0]  cmd_rs2;
  logic [WIDTH-1:0] cmd_imm;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;

  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic [RA_W-1:0]  res_rd;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, alu_result,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_rd
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, alu_result,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_rd
  );
endinterface

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile
//   NREGS x WIDTH register file for the sequencer.
//   clk, rst_n        : clock, asynchronous active-low clear of every entry
//   we/waddr/wdata    : synchronous write port
//   raddr1/rdata1     : combinational read port (operand A)
//   raddr2/rdata2     : combinational read port (operand B)
//   dbg_addr/dbg_data : combinational debug read port
module alu_seq_regfile #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int RA_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [RA_W-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [RA_W-1:0]  raddr1,
  output logic [WIDTH-1:0] rdata1,
  input  logic [RA_W-1:0]  raddr2,
  output logic [WIDTH-1:0] rdata2,
  input  logic [RA_W-1:0]  dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  // Reads see registered state only: a write at edge T is visible after T.
  assign rdata1   = regs_q[raddr1];
  assign rdata2   = regs_q[raddr2];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Issues one command at a time to a downstream registered ALU and writes
//   the result back into a local register file.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command handshake, ALU operand/select outputs, alu_result
//                input and the one-cycle res_valid/res_data/res_rd strobe
//   dbg_addr   : debug read address
//   dbg_data   : combinational read of the addressed register
//   ALU op: IDLE -(accept)-> EXEC -> WB -(write)-> IDLE, 2 cycles to res_valid.
//   LDI: written at the accept edge, stays in IDLE, one per cycle.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int RA_W  = RA_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_seq_if.slave         bus,
  input  logic [RA_W-1:0]  dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic [RA_W-1:0]  rd_q, rd_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [RA_W-1:0]  res_rd_q, res_rd_d;

  logic             accept;
  logic             we;
  logic [RA_W-1:0]  waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata1, rdata2;

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  alu_seq_regfile #(
    .WIDTH(WIDTH),
    .NREGS(NREGS),
    .RA_W (RA_W)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr1  (bus.cmd_rs1),
    .rdata1  (rdata1),
    .raddr2  (bus.cmd_rs2),
    .rdata2  (rdata2),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    rd_d      = rd_q;
    we        = 1'b0;
    waddr     = rd_q;
    wdata     = bus.alu_result;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.cmd_op == OP_LDI) begin
            we    = 1'b1;
            waddr = bus.cmd_rd;
            wdata = bus.cmd_imm;
          end else if (is_alu_op(bus.cmd_op)) begin
            // Operands are captured here and then held until the next ALU op.
            alu_a_d   = rdata1;
            alu_b_d   = rdata2;
            alu_sel_d = bus.cmd_op;
            rd_d      = bus.cmd_rd;
            state_d   = S_EXEC;
          end
        end
      end
      S_EXEC:  state_d = S_WB;       // ALU registers the operands at this edge
      S_WB: begin
        we      = 1'b1;              // alu_result is valid this cycle
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The strobe mirrors the write port; data/rd hold between writes.
    res_valid_d = we;
    res_data_d  = we ? wdata : res_data_q;
    res_rd_d    = we ? waddr : res_rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rd_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rd_q        <= rd_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_rd    = res_rd_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Drives directed and random commands into alu_sequencer, stands in for the
//   downstream registered ALU, and checks every strobe, operand and register
//   against a command-level model of the register file.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  alu_seq_if #(.WIDTH(4), .RA_W(2)) bus ();

  alu_sequencer #(.WIDTH(4), .NREGS(4), .RA_W(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream ALU: one register stage from operands to result.
  function automatic logic [3:0] alu_f(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
    case (sel)
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a - b;
      OP_NOTA: alu_f = ~a;
      OP_NOTB: alu_f = ~b;
      OP_XOR:  alu_f = a ^ b;
      OP_OR:   alu_f = a | b;
      OP_AND:  alu_f = a & b;
      default: alu_f = 4'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.alu_result <= 4'h0;
    else        bus.alu_result <= alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);
  end

  // Command-level reference: integer arithmetic reduced modulo 16.
  function automatic logic [3:0] ref_alu(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int x, y, r;
    x = int'(a);
    y = int'(b);
    case (op)
      4'd2:    r = (x + y) % 16;
      4'd3:    r = (x - y + 16) % 16;
      4'd4:    r = 15 - x;
      4'd5:    r = 15 - y;
      4'd6:    r = x ^ y;
      4'd7:    r = x | y;
      4'd8:    r = x & y;
      default: r = 0;
    endcase
    return r[3:0];
  endfunction

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] ref_regs [4];
  logic [3:0] last_a, last_b, last_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = i[1:0];
      #1;
      chk($sformatf("%s_r%0d", tag, i), {28'h0, dbg_data}, {28'h0, ref_regs[i]});
    end
  endtask

  task automatic junk_cmd();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = ($urandom_range(0, 1) != 0) ? OP_LDI : 4'($urandom_range(0, 15));
    bus.cmd_rd    = 2'($urandom_range(0, 3));
    bus.cmd_rs1   = 2'($urandom_range(0, 3));
    bus.cmd_rs2   = 2'($urandom_range(0, 3));
    bus.cmd_imm   = 4'($urandom_range(0, 15));
  endtask

  // Issue one command from IDLE and check it through to completion.
  // Returns at #1 after the edge that makes cmd_ready high again.
  task automatic run_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [3:0] imm, input bit junk);
    logic [3:0] exp;
    chk("ready_pre", {31'h0, bus.cmd_ready}, 32'h1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    bus.cmd_imm   = imm;
    @(posedge clk); #1;
    if (op == OP_LDI || op == OP_NOP) begin
      bus.cmd_valid = 1'b0;
      if (op == OP_LDI) begin
        ref_regs[rd] = imm;
        chk("ldi_res_valid", {31'h0, bus.res_valid}, 32'h1);
        chk("ldi_res_data",  {28'h0, bus.res_data},  {28'h0, imm});
        chk("ldi_res_rd",    {30'h0, bus.res_rd},    {30'h0, rd});
      end else begin
        chk("nop_res_valid", {31'h0, bus.res_valid}, 32'h0);
      end
      chk("local_ready",    {31'h0, bus.cmd_ready}, 32'h1);
      chk("hold_alu_a",     {28'h0, bus.alu_a},     {28'h0, last_a});
      chk("hold_alu_b",     {28'h0, bus.alu_b},     {28'h0, last_b});
      chk("hold_alu_sel",   {28'h0, bus.alu_sel},   {28'h0, last_sel});
    end else begin
      exp      = ref_alu(op, ref_regs[rs1], ref_regs[rs2]);
      last_a   = ref_regs[rs1];
      last_b   = ref_regs[rs2];
      last_sel = op;
      if (junk) junk_cmd(); else bus.cmd_valid = 1'b0;
      chk("exec_alu_a",     {28'h0, bus.alu_a},     {28'h0, last_a});
      chk("exec_alu_b",     {28'h0, bus.alu_b},     {28'h0, last_b});
      chk("exec_alu_sel",   {28'h0, bus.alu_sel},   {28'h0, op});
      chk("exec_ready",     {31'h0, bus.cmd_ready}, 32'h0);
      chk("exec_res_valid", {31'h0, bus.res_valid}, 32'h0);
      @(posedge clk); #1;
      if (junk) junk_cmd();
      chk("wb_ready",       {31'h0, bus.cmd_ready}, 32'h0);
      chk("wb_res_valid",   {31'h0, bus.res_valid}, 32'h0);
      chk("wb_alu_a",       {28'h0, bus.alu_a},     {28'h0, last_a});
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      ref_regs[rd]  = exp;
      chk("op_res_valid",   {31'h0, bus.res_valid}, 32'h1);
      chk("op_res_data",    {28'h0, bus.res_data},  {28'h0, exp});
      chk("op_res_rd",      {30'h0, bus.res_rd},    {30'h0, rd});
      chk("op_ready_post",  {31'h0, bus.cmd_ready}, 32'h1);
    end
    check_regs("rf");
  endtask

  initial begin
    rst_n         = 1'b0;
    dbg_addr      = 2'd0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_rd    = 2'd0;
    bus.cmd_rs1   = 2'd0;
    bus.cmd_rs2   = 2'd0;
    bus.cmd_imm   = 4'h0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 4'h0;
    last_a = 4'h0; last_b = 4'h0; last_sel = 4'h0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready",     {31'h0, bus.cmd_ready}, 32'h1);
    chk("rst_res_valid", {31'h0, bus.res_valid}, 32'h0);
    chk("rst_res_data",  {28'h0, bus.res_data},  32'h0);
    chk("rst_alu_sel",   {28'h0, bus.alu_sel},   32'h0);
    check_regs("rst");
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", {31'h0, bus.cmd_ready}, 32'h1);

    // Directed sequence
    run_cmd(OP_LDI, 2'd0, 2'd0, 2'd0, 4'h3, 1'b0);   // back-to-back LDIs
    run_cmd(OP_LDI, 2'd1, 2'd0, 2'd0, 4'h5, 1'b0);
    run_cmd(OP_ADD, 2'd2, 2'd0, 2'd1, 4'h0, 1'b0);   // 3+5 = 8
    run_cmd(OP_SUB, 2'd3, 2'd0, 2'd1, 4'h0, 1'b0);   // 3-5 wraps to E
    run_cmd(OP_XOR, 2'd2, 2'd3, 2'd1, 4'h0, 1'b0);   // E^5 = B
    run_cmd(OP_NOTA, 2'd1, 2'd0, 2'd0, 4'h0, 1'b0);  // ~3 = C
    run_cmd(4'hF, 2'd0, 2'd1, 2'd2, 4'h0, 1'b0);     // unassigned code writes 0
    run_cmd(OP_NOP, 2'd3, 2'd1, 2'd2, 4'h9, 1'b0);
    run_cmd(OP_OR,  2'd3, 2'd1, 2'd2, 4'h0, 1'b1);   // busy-time commands ignored
    run_cmd(OP_AND, 2'd0, 2'd3, 2'd2, 4'h0, 1'b1);

    // Reset during EXEC of an ADD
    run_cmd(OP_LDI, 2'd0, 2'd0, 2'd0, 4'h7, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_rd    = 2'd1;
    bus.cmd_rs1   = 2'd0;
    bus.cmd_rs2   = 2'd0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 4'h0;
    last_a = 4'h0; last_b = 4'h0; last_sel = 4'h0;
    #1;
    chk("mid_rst_res_valid", {31'h0, bus.res_valid}, 32'h0);
    chk("mid_rst_alu_a",     {28'h0, bus.alu_a},     32'h0);
    check_regs("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready", {31'h0, bus.cmd_ready}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_wb", {31'h0, bus.res_valid}, 32'h0);
    end
    check_regs("post_rst");

    // Random commands
    for (int n = 0; n < 200; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? OP_LDI : 4'($urandom_range(0, 15));
      run_cmd(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command sequencer that sits directly upstream of the 4-bit registered ALU. It owns a 4-entry × 4-bit register file and accepts one command at a time over a valid/ready handshake. For each command it drives the ALU operands and select, waits for the ALU's registered result, and writes that result back. It also reports the result on a one-cycle result strobe.

## Interface
Parameters:
- WIDTH, 4, datapath width; must match the ALU.
- NREGS, 4, register-file depth.
- RA_W, 2, register address width, equal to log2(NREGS).

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_op  in  4  opcode; ALU select codes plus local codes.
- cmd_rd  in  RA_W  destination register.
- cmd_rs1  in  RA_W  source register for A.
- cmd_rs2  in  RA_W  source register for B.
- cmd_imm  in  WIDTH  immediate, used by LDI only.
- alu_a  out  WIDTH  ALU operand A; registered.
- alu_b  out  WIDTH  ALU operand B; registered.
- alu_sel  out  4  ALU select; registered.
- alu_result  in  WIDTH  registered ALU output.
- res_valid  out  1  one-cycle strobe for a completed write.
- res_data  out  WIDTH  value written.
- res_rd  out  RA_W  register written.
- dbg_addr  in  RA_W  debug read address.
- dbg_data  out  WIDTH  combinational read of regs[dbg_addr].

## Operation
- Opcodes:
  - 0000 NOP.
  - 0001 LDI.
  - ALU ops: 0010 ADD, 0011 SUB, 0100 NOTA, 0101 NOTB, 0110 XOR, 0111 OR, 1000 AND.
  - 1001–1111 are passed to the ALU unchanged; the ALU returns 0, and 0 is written.
- A command is accepted on a posedge where cmd_valid and cmd_ready are both high.
- States:
  - IDLE: cmd_ready = 1.
    - ALU op accepted → EXEC. alu_a ← regs[rs1], alu_b ← regs[rs2], alu_sel ← op, latch rd.
    - LDI accepted → regs[rd] ← imm; res_valid/res_data/res_rd are set for the next cycle; stay in IDLE.
    - NOP accepted → no write, no res_valid; stay in IDLE.
  - EXEC: ALU operands are held stable; the ALU captures them at the end of this cycle. → WB.
  - WB: alu_result is valid. At the end of the cycle: regs[rd] ← alu_result, res_valid ← 1, res_data ← alu_result, res_rd ← rd. → IDLE.
- alu_a, alu_b and alu_sel hold their last values in IDLE. They change only when a new ALU op is accepted.
- Arithmetic is the ALU's: results are modulo 2^WIDTH with no carry or borrow out. The sequencer never modifies the result.
- Reset (asynchronous, any state, including mid-EXEC/WB):
  - state → IDLE, all regs → 0.
  - alu_a/alu_b/alu_sel → 0, res_valid/res_data/res_rd → 0.
  - The in-flight command is dropped with no write.
  - cmd_ready is high in the first cycle after deassertion.

## Timing
- ALU op accepted at edge T0: EXEC occupies T0→T1, WB occupies T1→T2, and the write plus the res_valid pulse happen at edge T2.
  - Accept-to-res_valid latency is 2 cycles.
  - cmd_ready is low during EXEC and WB. The next accept can occur at edge T2+1, giving one ALU op per 3 cycles.
- LDI: the write and res_valid are registered at the accept edge, so res_valid is high the next cycle. Back-to-back LDIs run at one per cycle.
- res_valid is high for exactly one cycle per completed write and never for NOP.
- A register written at edge T is visible to a read at an accept on edge T+1 (reads are of registered state).
- dbg_data reflects a write in the cycle after the write edge.
- cmd_* inputs are ignored when cmd_ready is low.

## Structure
- Package alu_seq_pkg holds:
  - the opcode localparams (OP_NOP, OP_LDI, OP_ADD … OP_AND);
  - the state encoding (S_IDLE, S_EXEC, S_WB);
  - WIDTH/NREGS defaults.
  - The ALU and the sequencer share the opcode constants from this package.
- One sub-module, alu_seq_regfile:
  - NREGS × WIDTH;
  - two combinational read ports plus the debug read port;
  - one synchronous write port;
  - asynchronous active-low clear.

## Test plan
- Reset, then LDI R0←3 and LDI R1←5 back-to-back → res_valid on two consecutive cycles; dbg reads R0 = 3, R1 = 5.
- ADD rd=R2, rs1=R0, rs2=R1 → alu_sel = 0010, alu_a = 3, alu_b = 5 during EXEC; res_valid 2 cycles after accept with res_data = 8, res_rd = 2; cmd_ready low for 2 cycles.
- SUB R3 = R0 − R1 → res_data = 4'hE (wrap). Follow with XOR R2 = R3 ^ R1 accepted the cycle after res_valid → operands use the new R3 = E; result = B.
- NOTA R1 = ~R0 → 4'hC. Opcode 1111 into R0 → R0 = 0. NOP → no res_valid and no register change.
- Assert rst_n low during EXEC of ADD → no write, res_valid stays 0, all regs read 0, cmd_ready = 1 in the first cycle after release.
- Hold cmd_valid high with changing cmd_* during EXEC/WB → only the command accepted in IDLE executes; no extra writes.
